// File: rtl/rv_pkg.sv
// Shared RV32 pipeline definitions: memory opcodes, funct3 access codes,
// data-memory responder states and regfile write-back source select.
package rv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } dmem_state_e;

  typedef enum logic [2:0] {
    SRC_ALU  = 3'd0,
    SRC_DMEM = 3'd1,
    SRC_PC4  = 3'd2,
    SRC_IMM  = 3'd3,
    SRC_CSR  = 3'd4
  } rf_src_e;

endpackage

// File: rtl/dmem_lane_ext.sv
// Byte-lane steering for the data memory: store enables/replication,
// load selection with sign/zero extension, and size/alignment fault check.
module dmem_lane_ext
  import rv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        write,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        fault
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = 8'(raw >> {addr_lo, 3'b000});
  assign half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    be        = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    fault     = 1'b0;
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{half_sel[15]}}, half_sel};
        fault     = addr_lo[0];
      end
      F3_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = raw;
        fault     = |addr_lo;
      end
      F3_BU: begin
        rdata_ext = {24'd0, byte_sel};
        fault     = write;
      end
      F3_HU: begin
        rdata_ext = {16'd0, half_sel};
        fault     = write | addr_lo[0];
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one load/store, waits WAIT_CYCLES,
// accesses the word array and returns extended load data with a fault flag.
module dmem_responder
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        stall
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  dmem_state_e   state;
  logic [3:0]    cnt;
  logic          wr_q;
  logic [2:0]    f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          idle;
  logic [2:0]    lx_funct3;
  logic          lx_write;
  logic [1:0]    lx_addr_lo;
  logic [3:0]    lx_be;
  logic [31:0]   lx_wdata_rep;
  logic [31:0]   lx_rdata_ext;
  logic          lx_fault;
  logic          range_fault;
  logic          req_fault;
  logic [AW-1:0] widx;

  assign idle      = (state == ST_IDLE);
  assign req_ready = idle;
  assign stall     = rst_n && ((idle && req_valid) || state == ST_WAIT || state == ST_ACCESS);

  // One lane unit serves both phases: the incoming request is checked in
  // IDLE, the latched request drives the array in ACCESS.
  assign lx_funct3  = idle ? req_funct3    : f3_q;
  assign lx_write   = idle ? req_write     : wr_q;
  assign lx_addr_lo = idle ? req_addr[1:0] : addr_q[1:0];
  assign widx       = addr_q[AW+1:2];

  dmem_lane_ext u_lane (
    .funct3    (lx_funct3),
    .write     (lx_write),
    .addr_lo   (lx_addr_lo),
    .wdata     (wdata_q),
    .raw       (mem[widx]),
    .be        (lx_be),
    .wdata_rep (lx_wdata_rep),
    .rdata_ext (lx_rdata_ext),
    .fault     (lx_fault)
  );

  assign range_fault = (req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign req_fault   = lx_fault | range_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      wr_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            f3_q    <= req_funct3;
            addr_q  <= req_addr[AW+1:0];
            wdata_q <= req_wdata;
            if (req_fault) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
            end else if (WAIT_CYCLES == 0) begin
              state <= ST_ACCESS;
            end else begin
              cnt   <= WAIT_INIT;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_ACCESS;
          else           cnt   <= cnt - 4'd1;
        end
        ST_ACCESS: begin
          state      <= ST_RESP;
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          resp_rdata <= wr_q ? '0 : lx_rdata_ext;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_ACCESS && wr_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lx_be[i]) mem[widx][8*i +: 8] <= lx_wdata_rep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH_WORDS=1024, WAIT_CYCLES=2).
module tb_dmem_responder;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        stall;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .stall      (stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts at posedge+1 with the DUT idle; returns after the DUT is idle again.
  // lat counts clock edges from the acceptance edge to the response cycle.
  task automatic xact(input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic flt, output int lat);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 32'hxxxx_xxxx;
    req_wdata = 32'hxxxx_xxxx;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
    rd  = resp_rdata;
    flt = resp_fault;
    @(posedge clk); #1;
  endtask

  task automatic do_ld(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] exp);
    logic [31:0] rd; logic flt; int lat;
    xact(1'b0, f3, a, 32'd0, rd, flt, lat);
    check({tag, "_data"}, rd, exp);
    check({tag, "_fault"}, 32'(flt), 32'd0);
    check({tag, "_lat"}, 32'(lat), 32'd4);
  endtask

  task automatic do_st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd; logic flt; int lat;
    xact(1'b1, f3, a, wd, rd, flt, lat);
    check("st_data", rd, 32'd0);
    check("st_lat", 32'(lat), 32'd4);
  endtask

  task automatic do_fault(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a);
    logic [31:0] rd; logic flt; int lat;
    xact(w, f3, a, 32'hAAAA_AAAA, rd, flt, lat);
    check({tag, "_fault"}, 32'(flt), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_data"}, rd, 32'd0);
  endtask

  initial begin
    logic [31:0] rd; logic flt; int lat;
    int pulses;
    int seen;

    rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b0;
    req_funct3 = F3_W; req_addr = 32'h10; req_wdata = 32'd0;
    repeat (2) @(posedge clk); #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rvalid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_rfault", 32'(resp_fault), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1; #1;
    check("stall_follow_hi", 32'(stall), 32'd1);
    req_valid = 1'b0; #1;
    check("stall_follow_lo", 32'(stall), 32'd0);
    @(posedge clk); #1;

    do_st(F3_W, 32'h10, 32'hDEAD_BEEF);
    do_ld("lw_10", F3_W, 32'h10, 32'hDEAD_BEEF);

    do_st(F3_W, 32'h10, 32'h0);
    do_st(F3_B, 32'h13, 32'h0000_0080);
    do_st(F3_H, 32'h10, 32'h0000_8001);
    do_ld("lw_lanes", F3_W, 32'h10, 32'h8000_8001);
    do_ld("lb_13", F3_B, 32'h13, 32'hFFFF_FF80);
    do_ld("lbu_13", F3_BU, 32'h13, 32'h0000_0080);
    do_ld("lh_10", F3_H, 32'h10, 32'hFFFF_8001);
    do_ld("lh_12", F3_H, 32'h12, 32'hFFFF_8000);
    do_ld("lhu_12", F3_HU, 32'h12, 32'h0000_8000);

    do_st(F3_W, 32'hFFC, 32'h1122_3344);
    do_ld("lw_last", F3_W, 32'hFFC, 32'h1122_3344);

    do_fault("lw_mis", 1'b0, F3_W, 32'h12);
    do_fault("lh_mis", 1'b0, F3_H, 32'h11);
    do_fault("f3_011", 1'b0, 3'b011, 32'h10);
    do_fault("range", 1'b0, F3_W, 32'h1000);
    do_fault("sbu", 1'b1, F3_BU, 32'h10);
    do_fault("sw_mis", 1'b1, F3_W, 32'h12);
    do_ld("after_sw_mis", F3_W, 32'h10, 32'h8000_8001);

    // Back-to-back: accepts at cycles 0,5,10 -> responses at 4,9,14.
    pulses = 0;
    req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = 32'd0;
    for (int c = 0; c < 20; c++) begin
      if (c == 0)  req_valid = 1'b1;
      if (c == 11) req_valid = 1'b0;
      #1;
      if (resp_valid) pulses++;
      check($sformatf("b2b_rv%0d", c), 32'(resp_valid), 32'((c == 4) || (c == 9) || (c == 14)));
      check($sformatf("b2b_st%0d", c), 32'(stall),
            32'((c < 14) && (c != 4) && (c != 9)));
      if (c == 4 || c == 9 || c == 14)
        check($sformatf("b2b_rd%0d", c), resp_rdata, 32'h8000_8001);
      @(posedge clk); #1;
    end
    check("b2b_pulses", 32'(pulses), 32'd3);

    do_st(F3_W, 32'h20, 32'hCAFE_F00D);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_W;
    req_addr = 32'h20; req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_stall", 32'(stall), 32'd1);
    rst_n = 1'b0; #1;
    check("mid_ready", 32'(req_ready), 32'd1);
    check("mid_rvalid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    check("mid_no_resp", 32'(seen), 32'd0);
    do_ld("mid_lw_20", F3_W, 32'h20, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
